st_packet_fifo: RTL and testbench
=================================

# st_packet_fifo

Parametrised single-clock Avalon-ST FIFO carrying packet framing (SOP, EOP, empty) plus fill-level and watermark flags. It sits between the Sobel pixel pipeline and the VGA controller's 30-bit streaming sink. It generalises the fixed streaming FIFO of the current system in three ways:
- configurable width and depth;
- programmable almost-full and almost-empty thresholds;
- an optional store-and-forward packet mode.

## Interface
Parameters:
- DATA_W, 30: symbol data width; 30 = 10-bit R,G,B for the VGA sink.
- EMPTY_W, 1: width of the empty field; minimum 1.
- DEPTH, 64: number of entries; power of two, at least 4.
- AF_THRESH, 60: almost_full asserts when fill_level ≥ AF_THRESH.
- AE_THRESH, 4: almost_empty asserts when fill_level ≤ AE_THRESH.
- PKT_MODE, 0: 0 = cut-through; 1 = store-and-forward.

Ports:
- clk_clk  in  1  single clock.
- reset_reset_n  in  1  asynchronous reset, active-low.
- in_data  in  DATA_W  sink data.
- in_valid  in  1  sink valid.
- in_ready  out  1  sink ready; ready latency 0.
- in_startofpacket  in  1  sink SOP.
- in_endofpacket  in  1  sink EOP.
- in_empty  in  EMPTY_W  sink empty symbols; meaningful only with EOP.
- out_data  out  DATA_W  source data.
- out_valid  out  1  source valid.
- out_ready  in  1  source ready; ready latency 0.
- out_startofpacket  out  1  source SOP.
- out_endofpacket  out  1  source EOP.
- out_empty  out  EMPTY_W  source empty.
- fill_level  out  log2(DEPTH)+1  number of stored entries.
- almost_full  out  1  watermark flag.
- almost_empty  out  1  watermark flag.

## Operation
- Each entry stores {empty, eop, sop, data}.
- Push: occurs when in_valid && in_ready.
- Pop: occurs when out_valid && out_ready.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Count: `count` runs 0..DEPTH.
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop together: count unchanged.
- in_ready = rst_done && (count != DEPTH).
  - rst_done is a flop: cleared by reset, set on the first clk_clk edge after reset_reset_n rises.
- Show-ahead output: out_data/sop/eop/empty always present the entry at the read pointer while out_valid is high. Their values while out_valid is low are don't-care.
- Cut-through mode (PKT_MODE=0): out_valid = (count != 0).
- Store-and-forward mode (PKT_MODE=1):
  - `pkt_cnt` (0..DEPTH) counts stored entries whose eop=1.
  - It increments on a push with EOP and decrements on a pop with EOP; both in one cycle leaves it unchanged.
  - out_valid = (count != 0) && (pkt_cnt != 0 || count == DEPTH).
  - The count == DEPTH term is an oversize fallback: a packet longer than DEPTH drains cut-through and cannot deadlock.
- Framing is passed through unchecked. A missing SOP/EOP is stored and forwarded as received; no correction and no dropping.
- Flags are combinational from registered count:
  - fill_level = count.
  - almost_full = (count ≥ AF_THRESH).
  - almost_empty = (count ≤ AE_THRESH).
- Data storage: inferred RAM with synchronous write and show-ahead read. Either an asynchronous-read array, or a registered read with a prefetch/bypass stage. Externally visible behaviour must match this spec either way.

## Timing
- Reset (asynchronous, reset_reset_n=0):
  - pointers, count and pkt_cnt = 0; rst_done = 0.
  - in_ready = 0, out_valid = 0, fill_level = 0, almost_full = 0 (when AF_THRESH > 0), almost_empty = 1.
  - out_sop/eop/empty/data = 0.
- Reset mid-operation: all contents are discarded immediately. No output handshake may complete while reset is low.
- Write-to-read latency: a word pushed at edge N gives out_valid=1 during cycle N+1, provided the mode allows it. fill_level updates at the same edge.
- Full: a word presented while count == DEPTH is not accepted (in_ready=0). A pop at edge N raises in_ready in cycle N+1. There is no combinational path from out_ready to in_ready.
- Empty: out_valid=0. A push at edge N shows its data in cycle N+1. There is no combinational path from in_valid to out_valid.
- Throughput: one push and one pop per cycle sustained at any 0 < count < DEPTH.
- Source rule: once asserted, out_valid and the output fields stay stable until popped, except on reset.

## Test plan
- Fill/drain, PKT_MODE=0, DEPTH=64:
  - Push 64 words 0x0..0x3F with out_ready=0 → in_ready drops after the 64th push; fill_level=64; almost_full from the 60th push.
  - Then out_ready=1 → 0x0..0x3F emerge in order; almost_empty asserts at fill_level=4; out_valid drops after 64 pops.
- Streaming: in_valid=1 and out_ready=1 continuously for 1000 cycles → one word per cycle, first output one cycle after the first push, fill_level constant at 1.
- Random backpressure: random in_valid/out_ready for 10k cycles → output sequence equals input sequence including sop/eop/empty; fill_level never exceeds 64.
- Store-and-forward, PKT_MODE=1:
  - Push a 10-beat packet (SOP on beat 0, EOP with empty=1 on beat 9) → out_valid stays 0 until the cycle after the EOP push.
  - Then all 10 beats emerge back-to-back.
- Oversize packet, PKT_MODE=1: push a 100-beat packet with out_ready=1 → out_valid rises when count reaches 64; all 100 beats are delivered in order with no deadlock.
- Reset mid-stream: assert reset_reset_n=0 with 20 entries stored → immediately fill_level=0, out_valid=0, in_ready=0.
  - After release: in_ready=1 one cycle later; the next pushed word is the first one output.

Source files
------------

// File: rtl/st_packet_fifo.sv
// Single-clock Avalon-ST FIFO with SOP/EOP/empty framing, fill level and watermarks.
// PKT_MODE=1 holds output until a whole packet (EOP) is stored, or the FIFO is full.
module st_packet_fifo #(
    parameter int DATA_W    = 30,
    parameter int EMPTY_W   = 1,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4,
    parameter int PKT_MODE  = 0
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_startofpacket,
    input  logic                      in_endofpacket,
    input  logic [EMPTY_W-1:0]        in_empty,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    output logic [EMPTY_W-1:0]        out_empty,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      almost_full,
    output logic                      almost_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = EMPTY_W + 2 + DATA_W;
    localparam int EOP_BIT = DATA_W + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, r_pkt_cnt;
    logic          r_rst_done;

    logic          w_push, w_pop, w_valid;
    logic          w_pkt_inc, w_pkt_dec;
    logic [EW-1:0] w_head;

    assign w_head   = r_mem[r_rd_ptr];
    assign in_ready = r_rst_done && (r_count != FULL_LVL);

    // The full-FIFO term lets an oversize packet drain instead of deadlocking.
    assign w_valid  = (r_count != '0) &&
                      ((PKT_MODE == 0) || (r_pkt_cnt != '0) || (r_count == FULL_LVL));

    assign w_push    = in_valid && in_ready;
    assign w_pop     = w_valid && out_ready;
    assign w_pkt_inc = w_push && in_endofpacket;
    assign w_pkt_dec = w_pop && w_head[EOP_BIT];

    // Fields are forced to zero while nothing is offered so reset presents clean outputs.
    assign out_valid = w_valid;
    assign {out_empty, out_endofpacket, out_startofpacket, out_data} = w_valid ? w_head : '0;

    assign fill_level   = r_count;
    assign almost_full  = (r_count >= AF_LVL);
    assign almost_empty = (r_count <= AE_LVL);

    always_ff @(posedge clk_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {in_empty, in_endofpacket, in_startofpacket, in_data};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rst_done <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_st_packet_fifo.sv
// Bench for st_packet_fifo: one cut-through and one store-and-forward instance
// checked every cycle against a queue-based model of the FIFO contents.
module tb_st_packet_fifo;
    localparam int DATA_W  = 30;
    localparam int EMPTY_W = 2;
    localparam int DEPTH   = 64;
    localparam int AF      = 60;
    localparam int AE      = 4;
    localparam int EW      = EMPTY_W + 2 + DATA_W;
    localparam int EOPB    = DATA_W + 1;
    localparam int OW      = 4 + 7 + EW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0]  a_in_data, a_out_data, b_in_data, b_out_data;
    logic               a_in_valid, a_in_ready, a_in_sop, a_in_eop, a_out_valid, a_out_ready;
    logic               a_out_sop, a_out_eop, a_af, a_ae;
    logic               b_in_valid, b_in_ready, b_in_sop, b_in_eop, b_out_valid, b_out_ready;
    logic               b_out_sop, b_out_eop, b_af, b_ae;
    logic [EMPTY_W-1:0] a_in_empty, a_out_empty, b_in_empty, b_out_empty;
    logic [6:0]         a_fill, b_fill;

    st_packet_fifo #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH),
                     .AF_THRESH(AF), .AE_THRESH(AE), .PKT_MODE(0)) u_ct (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_startofpacket(a_in_sop), .in_endofpacket(a_in_eop), .in_empty(a_in_empty),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop), .out_empty(a_out_empty),
        .fill_level(a_fill), .almost_full(a_af), .almost_empty(a_ae));

    st_packet_fifo #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH),
                     .AF_THRESH(AF), .AE_THRESH(AE), .PKT_MODE(1)) u_sf (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop), .in_empty(b_in_empty),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop), .out_empty(b_out_empty),
        .fill_level(b_fill), .almost_full(b_af), .almost_empty(b_ae));

    // Model: stored words per instance, plus "one clock seen since reset released".
    logic [EW-1:0] qa[$], qb[$];
    logic          mrd = 1'b0;
    int            npass = 0, ntot = 0;
    localparam logic [EW-1:0] IDLE = '0;

    function automatic logic [EW-1:0] ent(logic sop, logic eop, logic [EMPTY_W-1:0] emp,
                                          logic [DATA_W-1:0] d);
        return {emp, eop, sop, d};
    endfunction

    function automatic logic [EW-1:0] rnd_ent(int eop_mod);
        logic [31:0] r;
        r = $urandom();
        return ent(r[0], ($urandom_range(eop_mod - 1) == 0), r[2:1], DATA_W'($urandom()));
    endfunction

    function automatic logic va();
        return qa.size() != 0;
    endfunction

    function automatic logic vb();
        int e = 0;
        foreach (qb[i]) if (qb[i][EOPB]) e++;
        return (qb.size() != 0) && (e != 0 || qb.size() == DEPTH);
    endfunction

    function automatic logic [OW-1:0] exp_a();
        logic v = va();
        return {mrd && qa.size() != DEPTH, v, qa.size() >= AF, qa.size() <= AE,
                7'(qa.size()), v ? qa[0] : IDLE};
    endfunction

    function automatic logic [OW-1:0] exp_b();
        logic v = vb();
        return {mrd && qb.size() != DEPTH, v, qb.size() >= AF, qb.size() <= AE,
                7'(qb.size()), v ? qb[0] : IDLE};
    endfunction

    function automatic logic [OW-1:0] obs_a();
        return {a_in_ready, a_out_valid, a_af, a_ae, a_fill,
                a_out_valid ? {a_out_empty, a_out_eop, a_out_sop, a_out_data} : IDLE};
    endfunction

    function automatic logic [OW-1:0] obs_b();
        return {b_in_ready, b_out_valid, b_af, b_ae, b_fill,
                b_out_valid ? {b_out_empty, b_out_eop, b_out_sop, b_out_data} : IDLE};
    endfunction

    // Drives one cycle on both instances from a negedge, advances the model at posedge,
    // returns at the following negedge.
    task automatic step(input logic aiv, input logic [EW-1:0] aw, input logic aor,
                        input logic biv, input logic [EW-1:0] bw, input logic bor);
        logic pa, pb, oa, ob;
        {a_in_empty, a_in_eop, a_in_sop, a_in_data} = aw;
        {b_in_empty, b_in_eop, b_in_sop, b_in_data} = bw;
        a_in_valid = aiv; a_out_ready = aor;
        b_in_valid = biv; b_out_ready = bor;
        pa = aiv && mrd && qa.size() < DEPTH;
        pb = biv && mrd && qb.size() < DEPTH;
        oa = aor && va();
        ob = bor && vb();
        @(posedge clk);
        if (oa) void'(qa.pop_front());
        if (ob) void'(qb.pop_front());
        if (pa) qa.push_back(aw);
        if (pb) qb.push_back(bw);
        if (rst_n) mrd = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete(); qb.delete(); mrd = 1'b0;
        step(0, IDLE, 0, 0, IDLE, 0);
        rst_n = 1'b1;
        step(0, IDLE, 0, 0, IDLE, 0);
    endtask

    task automatic test_reset();
        repeat (2) step(0, IDLE, 1, 0, IDLE, 1);
        ntot++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            $display("FAIL reset_state: got %h/%h want %h/%h", obs_a(), obs_b(), exp_a(), exp_b());
        end else npass++;
        ntot++;
        if ({a_out_data, a_out_sop, a_out_eop, a_out_empty,
             b_out_data, b_out_sop, b_out_eop, b_out_empty} !== '0) begin
            $display("FAIL reset_fields: got %h %h want 0", a_out_data, b_out_data);
        end else npass++;
        rst_n = 1'b1;
        #1;
        ntot++;
        if ({a_in_ready, b_in_ready} !== 2'b00) begin
            $display("FAIL ready_before_edge: got %b want 00", {a_in_ready, b_in_ready});
        end else npass++;
        @(negedge clk);
        step(0, IDLE, 0, 0, IDLE, 0);
        ntot++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            $display("FAIL ready_after_release: got %h/%h want %h/%h", obs_a(), obs_b(), exp_a(), exp_b());
        end else npass++;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, ent(0, 0, 0, DATA_W'(i)), 0, 0, IDLE, 0);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL fill push %0d: got %h want %h", i, obs_a(), exp_a());
            end else npass++;
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(0, IDLE, 1, 0, IDLE, 0);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL drain pop %0d: got %h want %h", i, obs_a(), exp_a());
            end else npass++;
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step(1, ent(i == 0, i == 999, 2'(i), DATA_W'(i * 7)), 1, 0, IDLE, 0);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL stream cyc %0d: got %h want %h", i, obs_a(), exp_a());
            end else npass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(3) != 0, rnd_ent(8), $urandom_range(2) != 0,
                 $urandom_range(1) != 0, rnd_ent(6), $urandom_range(3) != 0);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL random cyc %0d: got %h/%h want %h/%h", i, obs_a(), obs_b(), exp_a(), exp_b());
            end else npass++;
        end
    endtask

    task automatic test_sf_packet();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, IDLE, 0, 1, ent(i == 0, i == 9, (i == 9) ? 2'd1 : 2'd0, DATA_W'(100 + i)), 1);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL sf_push beat %0d: got %h want %h", i, obs_b(), exp_b());
            end else npass++;
        end
        for (int i = 0; i < 12; i++) begin
            step(0, IDLE, 0, 0, IDLE, 1);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL sf_drain cyc %0d: got %h want %h", i, obs_b(), exp_b());
            end else npass++;
        end
    endtask

    task automatic test_oversize();
        int sent = 0;
        do_reset();
        for (int c = 0; c < 400 && sent < 100; c++) begin
            logic acc;
            acc = qb.size() < DEPTH;
            step(0, IDLE, 0, 1, ent(sent == 0, sent == 99, 0, DATA_W'(sent)), 1);
            if (acc) sent++;
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL oversize cyc %0d: got %h want %h", c, obs_b(), exp_b());
            end else npass++;
        end
        for (int i = 0; i < 150; i++) begin
            step(0, IDLE, 0, 0, IDLE, 1);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL oversize_drain cyc %0d: got %h want %h", i, obs_b(), exp_b());
            end else npass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, rnd_ent(4), 0, 1, ent(0, 0, 0, DATA_W'(i)), 0);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL preload %0d: got %h/%h want %h/%h", i, obs_a(), obs_b(), exp_a(), exp_b());
            end else npass++;
        end
        rst_n = 1'b0;
        qa.delete(); qb.delete(); mrd = 1'b0;
        #1;
        ntot++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            $display("FAIL mid_reset_async: got %h/%h want %h/%h", obs_a(), obs_b(), exp_a(), exp_b());
        end else npass++;
        ntot++;
        if ({a_out_data, a_out_empty, b_out_data, b_out_empty} !== '0) begin
            $display("FAIL mid_reset_fields: got %h %h want 0", a_out_data, b_out_data);
        end else npass++;
        @(negedge clk);
        step(1, rnd_ent(2), 1, 1, rnd_ent(1), 1);
        rst_n = 1'b1;
        step(0, IDLE, 1, 0, IDLE, 1);
        ntot++;
        if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
            $display("FAIL post_reset_ready: got %h/%h want %h/%h", obs_a(), obs_b(), exp_a(), exp_b());
        end else npass++;
        for (int i = 0; i < 6; i++) begin
            step(i < 3, ent(1, 1, 2'd3, DATA_W'(32'h2AAA_0000 + i)), i > 1,
                 i < 3, ent(1, 1, 2'd2, DATA_W'(32'h1555_0000 + i)), i > 1);
            ntot++;
            if ({obs_a(), obs_b()} !== {exp_a(), exp_b()}) begin
                $display("FAIL post_reset_data %0d: got %h/%h want %h/%h", i, obs_a(), obs_b(), exp_a(), exp_b());
            end else npass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;
        {a_in_empty, a_in_eop, a_in_sop, a_in_data} = IDLE;
        {b_in_empty, b_in_eop, b_in_sop, b_in_data} = IDLE;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_streaming();
        test_random();
        test_sf_packet();
        test_oversize();
        test_mid_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
